// File: rtl/sdr_emu_pkg.sv
// Shared types and constants for the SDRAM controller user-interface emulator.
package sdr_emu_pkg;

  typedef enum logic [1:0] {
    ST_INIT    = 2'd0,
    ST_IDLE    = 2'd1,
    ST_REFRESH = 2'd2
  } state_e;

  // Galois form of x^16+x^14+x^13+x^11+1
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Bits needed to hold 0 .. value-1 (never less than 1).
  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/sdr_app_emu_if.sv
// Application-side request/response bundle of the SDRAM controller user interface.
interface sdr_app_emu_if #(
  parameter int MEM_DATA_BITS = 32,
  parameter int ADDR_BITS     = 21
);

  logic                       App_wr_en;
  logic [ADDR_BITS-1:0]       App_wr_addr;
  logic [MEM_DATA_BITS-1:0]   App_wr_din;
  logic [MEM_DATA_BITS/8-1:0] App_wr_dm;
  logic                       App_rd_en;
  logic [ADDR_BITS-1:0]       App_rd_addr;
  logic                       Sdr_init_done;
  logic                       Sdr_init_ref_vld;
  logic                       Sdr_busy;
  logic                       Sdr_rd_en;
  logic [MEM_DATA_BITS-1:0]   Sdr_rd_dout;
  logic                       proto_err;

  modport master (
    output App_wr_en, App_wr_addr, App_wr_din, App_wr_dm, App_rd_en, App_rd_addr,
    input  Sdr_init_done, Sdr_init_ref_vld, Sdr_busy, Sdr_rd_en, Sdr_rd_dout, proto_err
  );

  modport slave (
    input  App_wr_en, App_wr_addr, App_wr_din, App_wr_dm, App_rd_en, App_rd_addr,
    output Sdr_init_done, Sdr_init_ref_vld, Sdr_busy, Sdr_rd_en, Sdr_rd_dout, proto_err
  );

endinterface

// File: rtl/sdr_emu_rd_pipe.sv
// Backing RAM with byte-masked writes and a fixed-latency read pipeline;
// the RAM is read in the last stage so the output lands RD_LATENCY cycles after the request.
module sdr_emu_rd_pipe #(
  parameter int DATA_BITS  = 32,
  parameter int DEPTH_BITS = 10,
  parameter int RD_LATENCY = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [DEPTH_BITS-1:0]  wr_addr,
  input  logic [DATA_BITS-1:0]   wr_data,
  input  logic [DATA_BITS/8-1:0] wr_mask,
  input  logic                   rd_req,
  input  logic [DEPTH_BITS-1:0]  rd_addr,
  output logic                   rd_valid,
  output logic [DATA_BITS-1:0]   rd_data,
  output logic                   empty
);

  localparam int STAGES = RD_LATENCY - 1;

  logic [DATA_BITS-1:0]  mem [2**DEPTH_BITS];
  logic [STAGES-1:0]     stage_vld;
  logic [DEPTH_BITS-1:0] stage_addr [STAGES];

  // NOTE: the RAM array has no reset; clearing it would prevent block-RAM mapping.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < DATA_BITS/8; b++) begin
        if (!wr_mask[b]) mem[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_vld <= '0;
    end else begin
      stage_vld[0] <= rd_req;
      for (int i = 1; i < STAGES; i++) stage_vld[i] <= stage_vld[i-1];
    end
  end

  always_ff @(posedge clk) begin
    stage_addr[0] <= rd_addr;
    for (int i = 1; i < STAGES; i++) stage_addr[i] <= stage_addr[i-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= stage_vld[STAGES-1];
      if (stage_vld[STAGES-1]) rd_data <= mem[stage_addr[STAGES-1]];
    end
  end

  assign empty = ~(|stage_vld) & ~rd_valid;

endmodule

// File: rtl/sdr_app_emu.sv
// On-chip stand-in for the SDRAM controller user interface: init delay, refresh blackouts,
// fixed read latency. Define SDR_EMU_STALL_EN to add pseudo-random single-cycle back-pressure.
module sdr_app_emu
  import sdr_emu_pkg::*;
#(
  parameter int MEM_DATA_BITS = 32,
  parameter int ADDR_BITS     = 21,
  parameter int DEPTH_BITS    = 10,
  parameter int INIT_CYCLES   = 200,
  parameter int REF_PERIOD    = 780,
  parameter int REF_CYCLES    = 8,
  parameter int RD_LATENCY    = 4
) (
  input logic         mem_clk,
  input logic         rst_n,
  sdr_app_emu_if.slave app
);

  localparam int CNT_W = clog2((INIT_CYCLES > REF_CYCLES) ? INIT_CYCLES : REF_CYCLES);
  localparam int REF_W = clog2(REF_PERIOD);

  state_e           state, state_next;
  logic [CNT_W-1:0] phase_cnt;
  logic [REF_W-1:0] ref_cnt;
  logic             ref_pending, ref_expire;
  logic             pipe_empty, stall, busy;
  logic             init_done, init_ref_vld, proto_err_q;
  logic             wr_accept, rd_accept, drop;
  logic             unused_addr_bits;

  always_ff @(posedge mem_clk or negedge rst_n) begin
    if (!rst_n) state <= ST_INIT;
    else        state <= state_next;
  end

  // NOTE: combinational blocks assign every output a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      ST_INIT:    if (phase_cnt == CNT_W'(INIT_CYCLES - 1)) state_next = ST_IDLE;
      ST_IDLE:    if (ref_pending && pipe_empty)            state_next = ST_REFRESH;
      ST_REFRESH: if (phase_cnt == CNT_W'(REF_CYCLES - 1))  state_next = ST_IDLE;
      default:    state_next = ST_INIT;
    endcase
  end

  always_comb begin
    init_done    = 1'b1;
    init_ref_vld = 1'b0;
    busy         = ref_pending | stall;
    case (state)
      ST_INIT: begin
        init_done    = 1'b0;
        init_ref_vld = 1'b1;
        busy         = 1'b1;
      end
      ST_REFRESH: begin
        init_ref_vld = 1'b1;
        busy         = 1'b1;
      end
      default: ;
    endcase
  end

  // Shared INIT/REFRESH duration counter, restarted on every state change.
  always_ff @(posedge mem_clk or negedge rst_n) begin
    if (!rst_n)                     phase_cnt <= '0;
    else if (state_next != state)   phase_cnt <= '0;
    else if (state != ST_IDLE)      phase_cnt <= phase_cnt + CNT_W'(1);
  end

  assign ref_expire = (state != ST_INIT) && (ref_cnt == REF_W'(REF_PERIOD - 1));

  always_ff @(posedge mem_clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_cnt     <= '0;
      ref_pending <= 1'b0;
    end else begin
      if (ref_expire)             ref_cnt <= '0;
      else if (state != ST_INIT)  ref_cnt <= ref_cnt + REF_W'(1);

      if (ref_expire)                                      ref_pending <= 1'b1;
      else if (state == ST_IDLE && state_next == ST_REFRESH) ref_pending <= 1'b0;
    end
  end

`ifdef SDR_EMU_STALL_EN
  logic [15:0] lfsr;

  always_ff @(posedge mem_clk or negedge rst_n) begin
    if (!rst_n)                lfsr <= LFSR_SEED;
    else if (state == ST_IDLE) lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
  end

  assign stall = (state == ST_IDLE) && (lfsr[3:0] == 4'h0);
`else
  assign stall = 1'b0;
`endif

  // A simultaneous read loses to the write; anything offered while busy is dropped.
  assign wr_accept = app.App_wr_en && !busy;
  assign rd_accept = app.App_rd_en && !app.App_wr_en && !busy;
  assign drop      = (app.App_wr_en && app.App_rd_en) || ((app.App_wr_en || app.App_rd_en) && busy);

  always_ff @(posedge mem_clk or negedge rst_n) begin
    if (!rst_n)    proto_err_q <= 1'b0;
    else if (drop) proto_err_q <= 1'b1;
  end

  sdr_emu_rd_pipe #(
    .DATA_BITS  (MEM_DATA_BITS),
    .DEPTH_BITS (DEPTH_BITS),
    .RD_LATENCY (RD_LATENCY)
  ) u_rd_pipe (
    .clk      (mem_clk),
    .rst_n    (rst_n),
    .wr_en    (wr_accept),
    .wr_addr  (app.App_wr_addr[DEPTH_BITS-1:0]),
    .wr_data  (app.App_wr_din),
    .wr_mask  (app.App_wr_dm),
    .rd_req   (rd_accept),
    .rd_addr  (app.App_rd_addr[DEPTH_BITS-1:0]),
    .rd_valid (app.Sdr_rd_en),
    .rd_data  (app.Sdr_rd_dout),
    .empty    (pipe_empty)
  );

  // Upper address bits wrap onto the emulated depth.
  assign unused_addr_bits = ^{app.App_wr_addr[ADDR_BITS-1:DEPTH_BITS],
                              app.App_rd_addr[ADDR_BITS-1:DEPTH_BITS]};

  assign app.Sdr_init_done    = init_done;
  assign app.Sdr_init_ref_vld = init_ref_vld;
  assign app.Sdr_busy         = busy;
  assign app.proto_err        = proto_err_q;

endmodule

// File: tb/tb_sdr_app_emu.sv
// Directed self-checking bench for sdr_app_emu with default parameters.
module tb_sdr_app_emu;

  localparam int DW = 32;
  localparam int AW = 21;

  logic mem_clk = 1'b0;
  logic rst_n   = 1'b0;
  int   checks  = 0;
  int   errors  = 0;
  int   t       = 0;
  logic [DW-1:0] fill [8];

  sdr_app_emu_if #(.MEM_DATA_BITS(DW), .ADDR_BITS(AW)) bus ();

  sdr_app_emu #(
    .MEM_DATA_BITS (DW),
    .ADDR_BITS     (AW),
    .DEPTH_BITS    (10),
    .INIT_CYCLES   (200),
    .REF_PERIOD    (780),
    .REF_CYCLES    (8),
    .RD_LATENCY    (4)
  ) dut (
    .mem_clk (mem_clk),
    .rst_n   (rst_n),
    .app     (bus)
  );

  always #5 mem_clk = ~mem_clk;

  task automatic check(input string tag, input logic [DW-1:0] observed, input logic [DW-1:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge mem_clk);
    #1;
    t++;
  endtask

  task automatic clear_inputs();
    bus.App_wr_en   = 1'b0;
    bus.App_wr_addr = '0;
    bus.App_wr_din  = '0;
    bus.App_wr_dm   = '0;
    bus.App_rd_en   = 1'b0;
    bus.App_rd_addr = '0;
  endtask

  task automatic write(input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic [3:0] dm);
    bus.App_wr_en   = 1'b1;
    bus.App_wr_addr = addr;
    bus.App_wr_din  = data;
    bus.App_wr_dm   = dm;
    tick();
    bus.App_wr_en   = 1'b0;
  endtask

  // Read must show up exactly four cycles after it is offered, for one cycle.
  task automatic do_read(input logic [AW-1:0] addr, input logic [DW-1:0] expected, input string tag);
    bus.App_rd_en   = 1'b1;
    bus.App_rd_addr = addr;
    tick();
    bus.App_rd_en   = 1'b0;
    tick();
    tick();
    check({tag, "_early"}, DW'(bus.Sdr_rd_en), DW'(0));
    tick();
    check({tag, "_valid"}, DW'(bus.Sdr_rd_en), DW'(1));
    check({tag, "_data"}, bus.Sdr_rd_dout, expected);
    tick();
    check({tag, "_single"}, DW'(bus.Sdr_rd_en), DW'(0));
  endtask

  task automatic init_wait(input string tag);
    for (int i = 1; i <= 200; i++) begin
      tick();
      if (i == 199) begin
        check({tag, "_done_199"}, DW'(bus.Sdr_init_done), DW'(0));
        check({tag, "_busy_199"}, DW'(bus.Sdr_busy), DW'(1));
      end
    end
    check({tag, "_done_200"}, DW'(bus.Sdr_init_done), DW'(1));
    check({tag, "_busy_200"}, DW'(bus.Sdr_busy), DW'(0));
    check({tag, "_irv_200"}, DW'(bus.Sdr_init_ref_vld), DW'(0));
    t = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clear_inputs();
    for (int i = 0; i < 8; i++) fill[i] = 32'hC0DE_0000 + DW'(i);

    // Reset values
    tick(); tick(); tick();
    check("rst_busy", DW'(bus.Sdr_busy), DW'(1));
    check("rst_irv", DW'(bus.Sdr_init_ref_vld), DW'(1));
    check("rst_done", DW'(bus.Sdr_init_done), DW'(0));
    check("rst_rd_en", DW'(bus.Sdr_rd_en), DW'(0));
    check("rst_dout", bus.Sdr_rd_dout, '0);
    check("rst_perr", DW'(bus.proto_err), DW'(0));
    rst_n = 1'b1;
    init_wait("init");

    // Write then immediate read, byte mask, address wrap
    write(21'd5, 32'h1122_3344, 4'b0000);
    do_read(21'd5, 32'h1122_3344, "rd5");
    write(21'd7, 32'hFFFF_FFFF, 4'b0000);
    write(21'd7, 32'h0000_0000, 4'b1010);
    do_read(21'd7, 32'hFF00_FF00, "mask7");
    write(21'd1025, 32'hCAFE_BABE, 4'b0000);
    do_read(21'd1, 32'hCAFE_BABE, "wrap1");
    check("perr_clean", DW'(bus.proto_err), DW'(0));

    // Burst of reads straddling the refresh request, plus a write during refresh
    for (int i = 0; i < 8; i++) write(AW'(i), fill[i], 4'b0000);
    while (t < 772) tick();
    for (int k = 0; k < 24; k++) begin
      bus.App_rd_en   = (k < 8);
      bus.App_rd_addr = AW'(k % 8);
      bus.App_wr_en   = (t + 1 == 788);
      bus.App_wr_addr = '0;
      bus.App_wr_din  = 32'hDEAD_BEEF;
      tick();
      if (t >= 776 && t <= 783) begin
        check("burst_rd_en", DW'(bus.Sdr_rd_en), DW'(1));
        check("burst_data", bus.Sdr_rd_dout, fill[t - 776]);
      end else begin
        check("burst_rd_idle", DW'(bus.Sdr_rd_en), DW'(0));
      end
      check("burst_irv", DW'(bus.Sdr_init_ref_vld), DW'(t >= 785 && t <= 792));
      check("burst_busy", DW'(bus.Sdr_busy), DW'(t >= 780 && t <= 792));
      check("burst_perr", DW'(bus.proto_err), DW'(t >= 788));
    end
    clear_inputs();
    do_read(21'd0, fill[0], "busy_wr_ignored");

    // Reset with a read in flight
    bus.App_rd_en   = 1'b1;
    bus.App_rd_addr = 21'd3;
    tick();
    bus.App_rd_en   = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", DW'(bus.Sdr_busy), DW'(1));
    check("midrst_perr", DW'(bus.proto_err), DW'(0));
    for (int i = 0; i < 4; i++) begin
      tick();
      check("midrst_no_rd", DW'(bus.Sdr_rd_en), DW'(0));
    end
    rst_n = 1'b1;
    init_wait("reinit");

    // Simultaneous write and read: write lands, read dropped, error latched
    check("both_perr_before", DW'(bus.proto_err), DW'(0));
    bus.App_wr_en   = 1'b1;
    bus.App_wr_addr = 21'd9;
    bus.App_wr_din  = 32'h0000_0099;
    bus.App_wr_dm   = 4'b0000;
    bus.App_rd_en   = 1'b1;
    bus.App_rd_addr = 21'd9;
    tick();
    clear_inputs();
    check("both_perr_after", DW'(bus.proto_err), DW'(1));
    for (int i = 0; i < 5; i++) begin
      tick();
      check("both_rd_dropped", DW'(bus.Sdr_rd_en), DW'(0));
    end
    do_read(21'd9, 32'h0000_0099, "both_wr_won");
    check("perr_sticky", DW'(bus.proto_err), DW'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sdr_app_emu.md
Name: sdr_app_emu

Overview:
- Synthesizable emulation of the SDRAM controller user interface: the responder side of the App_wr_*/App_rd_* request ports and the Sdr_* status/read-data ports.
- Backed by on-chip RAM, with init delay, periodic refresh blackouts and fixed read latency.
- Drops in place of the real controller, so the frame read/write path can be exercised on-board and in simulation without SDRAM.

Parameters:
MEM_DATA_BITS, 32, data word width (multiple of 8)
ADDR_BITS, 21, request address width
DEPTH_BITS, 10, emulated memory depth = 2**DEPTH_BITS words
INIT_CYCLES, 200, cycles from reset release to Sdr_init_done
REF_PERIOD, 780, cycles between refresh requests (>= REF_CYCLES+RD_LATENCY+2)
REF_CYCLES, 8, refresh blackout length
RD_LATENCY, 4, cycles from accepted App_rd_en to Sdr_rd_en (>=2)

Ports:
mem_clk  in  1  single clock
rst_n  in  1  asynchronous active-low reset
App_wr_en  in  1  write one word this cycle
App_wr_addr  in  ADDR_BITS  write word address
App_wr_din  in  MEM_DATA_BITS  write data
App_wr_dm  in  MEM_DATA_BITS/8  byte mask, 1 = byte not written
App_rd_en  in  1  read one word this cycle
App_rd_addr  in  ADDR_BITS  read word address
Sdr_init_done  out  1  init complete, sticky until reset
Sdr_init_ref_vld  out  1  high while in INIT or REFRESH
Sdr_busy  out  1  requests not accepted this cycle
Sdr_rd_en  out  1  read data valid
Sdr_rd_dout  out  MEM_DATA_BITS  read data
proto_err  out  1  sticky: a request was dropped

Behaviour:
- Reset values: all outputs 0 except Sdr_busy=1 and Sdr_init_ref_vld=1. Read pipeline flushed. Memory contents are not reset.
- Reset mid-operation: in-flight reads are discarded and no Sdr_rd_en is produced.
- States: INIT -> IDLE -> REFRESH -> IDLE.
- INIT:
  - Counter runs INIT_CYCLES.
  - On expiry: go to IDLE; Sdr_init_done=1 and Sdr_busy=0 on the same edge.
- Refresh timer:
  - Free-running counter starts on entry to IDLE and reloads at REF_PERIOD.
  - On expiry, ref_pending=1 and Sdr_busy=1 from the next cycle.
  - IDLE -> REFRESH once ref_pending=1 and the read pipeline is empty.
  - REFRESH lasts REF_CYCLES cycles, then back to IDLE; ref_pending clears on entry to REFRESH.
- Request acceptance: a request is accepted only when Sdr_busy=0 in that cycle.
- Write:
  - Lands on the clock edge at App_wr_addr[DEPTH_BITS-1:0]; upper address bits are ignored (wrap).
  - Only bytes with dm=0 are updated.
- Read:
  - Address captured at acceptance; Sdr_rd_en=1 with data exactly RD_LATENCY cycles later.
  - Back-to-back reads stream one word per cycle.
  - A read accepted in the cycle after a write to the same address returns the new data.
- Simultaneous App_wr_en and App_rd_en: the write wins, the read is dropped, proto_err=1.
- Any request while Sdr_busy=1 is dropped and sets proto_err=1; memory is unchanged.
- Sdr_busy = INIT | REFRESH | ref_pending (| stall, see Optional Feature).
- Reads already in the pipeline always complete, even while busy.

Optional Feature:
- Macro: SDR_EMU_STALL_EN.
- Defined:
  - 16-bit LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1) steps every cycle in IDLE.
  - When lfsr[3:0]==0, Sdr_busy is forced high for that single cycle, emulating controller back-pressure. proto_err rules unchanged.
- Undefined: no LFSR; busy only from INIT/REFRESH/ref_pending.

Decomposition:
- Package sdr_emu_pkg: state encoding (ST_INIT, ST_IDLE, ST_REFRESH), counter width function clog2, LFSR seed and tap constants.
- One sub-module: sdr_emu_rd_pipe. RD_LATENCY-deep valid/address shift register with RAM read in the final stage. It provides the empty flag used for refresh entry.

Test Plan:
- Reset, idle inputs -> Sdr_init_done rises exactly 200 cycles after rst_n release; Sdr_busy falls on the same edge; Sdr_init_ref_vld falls with it.
- Write 0x11223344 @5, next cycle read @5 -> Sdr_rd_en high 4 cycles after read; dout=0x11223344.
- Write 0xFFFFFFFF @7, then write 0x00000000 @7 with dm=4'b1010 -> read @7 returns 0xFF00FF00.
- 8 back-to-back reads @0..7 issued just before refresh expiry -> all 8 data beats are delivered; REFRESH entered only after the pipe drains; busy for 8 cycles in REFRESH.
- wr_en and rd_en together, and a write during Sdr_busy -> read dropped, write during busy ignored (memory unchanged), proto_err=1 sticky; deassert rst_n mid-read -> no Sdr_rd_en follows.
- Write @1025 with DEPTH_BITS=10 -> read @1 returns that data (wrap).
